// File: rtl/lcd_text_buffer_pkg.sv
// Shared constants, state encoding and frame slot mapping for the LCD text buffer.
package lcd_text_pkg;
  localparam int         LCD_CHARS  = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {IDLE, CLEAR, PULSE, HOLD} state_e;

  // MSB of character slot k inside the 256-bit frame; slot 0 sits at the top.
  function automatic int slot_msb(input int k);
    return 255 - 8 * k;
  endfunction
endpackage

// File: rtl/lcd_text_buffer_if.sv
// Character write port plus clear/commit request strobes.
interface lcd_text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       commit;

  modport master (output wr_valid, wr_addr, wr_char, clr_req, commit, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_char, clr_req, commit, output wr_ready);
endinterface

// File: rtl/lcd_text_buffer.sv
// Working/displayed character buffers with commit-driven LCD restart and holdoff.
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter int REFRESH_CYCLES = 96,
  parameter int RST_PULSE      = 2
) (
  input  logic                CLOCK,
  input  logic                ASYNC_RST,
  lcd_text_buffer_if.slave    bus,
  output logic [255:0]        frame,
  output logic                lcd_rst_n,
  output logic                busy
);
  localparam int HW = $clog2(REFRESH_CYCLES + 1);

  state_e          state_q, state_d;
  logic [4:0]      clr_cnt_q, clr_cnt_d;
  logic [3:0]      pls_cnt_q, pls_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            clr_pend_q, clr_pend_d;
  logic            cmt_pend_q, cmt_pend_d;
  logic [7:0]      wbuf_q  [LCD_CHARS];
  logic [7:0]      wbuf_d  [LCD_CHARS];
  logic [7:0]      frame_q [LCD_CHARS];
  logic            load_frame;
  logic            wr_ready_q, lcd_rst_n_q, busy_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    pls_cnt_d  = pls_cnt_q;
    hold_cnt_d = hold_cnt_q;
    clr_pend_d = clr_pend_q;
    cmt_pend_d = cmt_pend_q;
    wbuf_d     = wbuf_q;
    load_frame = 1'b0;

    if (bus.wr_valid && wr_ready_q)
      wbuf_d[bus.wr_addr] = bus.wr_char;

    if (state_q != IDLE) begin
      if (bus.clr_req) clr_pend_d = 1'b1;
      if (bus.commit)  cmt_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Same-cycle clear+commit: clear first, commit parked as pending.
        if (bus.clr_req || clr_pend_q) begin
          state_d    = CLEAR;
          clr_cnt_d  = '0;
          clr_pend_d = 1'b0;
          if (bus.commit) cmt_pend_d = 1'b1;
        end else if (bus.commit || cmt_pend_q) begin
          state_d    = PULSE;
          pls_cnt_d  = '0;
          cmt_pend_d = 1'b0;
          load_frame = 1'b1;
        end
      end
      CLEAR: begin
        wbuf_d[clr_cnt_q] = CHAR_SPACE;
        clr_cnt_d         = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          if (cmt_pend_d) begin
            state_d    = PULSE;
            pls_cnt_d  = '0;
            cmt_pend_d = 1'b0;
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PULSE: begin
        pls_cnt_d = pls_cnt_q + 4'd1;
        if (pls_cnt_q == 4'(RST_PULSE - 1)) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (hold_cnt_q == HW'(REFRESH_CYCLES - 1)) begin
          if (clr_pend_d) begin
            state_d    = CLEAR;
            clr_cnt_d  = '0;
            clr_pend_d = 1'b0;
          end else if (cmt_pend_d) begin
            state_d    = PULSE;
            pls_cnt_d  = '0;
            cmt_pend_d = 1'b0;
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset lands in PULSE so the controller re-initialises to a blank screen.
  always_ff @(posedge CLOCK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q     <= PULSE;
      clr_cnt_q   <= '0;
      pls_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      clr_pend_q  <= 1'b0;
      cmt_pend_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      for (int i = 0; i < LCD_CHARS; i++) begin
        wbuf_q[i]  <= CHAR_SPACE;
        frame_q[i] <= CHAR_SPACE;
      end
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pls_cnt_q   <= pls_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      clr_pend_q  <= clr_pend_d;
      cmt_pend_q  <= cmt_pend_d;
      wr_ready_q  <= (state_d == IDLE) || (state_d == HOLD);
      lcd_rst_n_q <= (state_d != PULSE);
      busy_q      <= (state_d != IDLE);
      wbuf_q      <= wbuf_d;
      if (load_frame) frame_q <= wbuf_d;
    end
  end

  for (genvar k = 0; k < LCD_CHARS; k++) begin : g_slot
    assign frame[slot_msb(k) -: 8] = frame_q[k];
  end

  assign bus.wr_ready = wr_ready_q;
  assign lcd_rst_n    = lcd_rst_n_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench: each expected restart pulse is queued; a monitor scores pulses as they appear.
module tb_lcd_text_buffer;
  logic         CLOCK = 1'b0;
  logic         ASYNC_RST;
  logic [255:0] frame;
  logic         lcd_rst_n;
  logic         busy;

  lcd_text_buffer_if bus();

  lcd_text_buffer #(.REFRESH_CYCLES(96), .RST_PULSE(2)) dut (
    .CLOCK(CLOCK), .ASYNC_RST(ASYNC_RST), .bus(bus),
    .frame(frame), .lcd_rst_n(lcd_rst_n), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [255:0] f;
    int           start;
  } exp_t;

  localparam logic [255:0] SP = {32{8'h20}};

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [255:0] putc(input logic [255:0] f, input int k, input logic [7:0] ch);
    f[255 - 8 * k -: 8] = ch;
    return f;
  endfunction

  // Monitor: every falling lcd_rst_n outside reset must match a queued expectation.
  logic prev_rn = 1'b0;
  logic meas    = 1'b0;
  int   plen    = 0;
  always @(negedge CLOCK) begin
    if (!ASYNC_RST) begin
      prev_rn <= 1'b0;
      meas    <= 1'b0;
    end else begin
      if (prev_rn && !lcd_rst_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: pulse at cycle %0d with no expectation queued", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_start", cyc, e.start);
          chk("pulse_frame", frame, e.f);
        end
        meas <= 1'b1;
        plen <= 1;
      end else if (meas && !lcd_rst_n) begin
        plen <= plen + 1;
      end else if (meas && lcd_rst_n) begin
        chk("pulse_len", plen, 2);
        meas <= 1'b0;
      end
      prev_rn <= lcd_rst_n;
    end
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] ch);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_char  = ch;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  initial begin
    int c, r;
    logic [255:0] ef, ef2;
    ASYNC_RST    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_char  = '0;
    bus.clr_req  = 1'b0;
    bus.commit   = 1'b0;
    repeat (3) step();

    chk("rst_lcd_rst_n", lcd_rst_n, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_frame", frame, SP);

    // Release: the release cycle is pulse cycle 0, so IDLE lands 98 edges later.
    ASYNC_RST = 1'b1;
    r = cyc;
    wait_to(r + 1);  chk("rel_rst_low", lcd_rst_n, 1'b0);
    wait_to(r + 2);  chk("rel_rst_high", lcd_rst_n, 1'b1);
    chk("rel_wr_ready_hold", bus.wr_ready, 1'b1);
    wait_to(r + 97); chk("rel_busy_hold", busy, 1'b1);
    wait_to(r + 98); chk("rel_busy_fall", busy, 1'b0);

    // "HI" on row 0, 'X' at row 1 col 0.
    wr(5'd0, 8'h48); wr(5'd1, 8'h49); wr(5'd16, 8'h58);
    ef = putc(putc(putc(SP, 0, 8'h48), 1, 8'h49), 16, 8'h58);
    c = cyc;
    exp_q.push_back('{ef, c + 1});
    do_commit();
    chk("hi_row0", frame[255:240], 16'h4849);
    chk("x_row1", frame[127:120], 8'h58);
    wait_to(c + 98); chk("commit_busy_hold", busy, 1'b1);
    wait_to(c + 99); chk("commit_busy_fall", busy, 1'b0);

    // Two commits during HOLD collapse into one pulse at HOLD expiry.
    c = cyc;
    exp_q.push_back('{ef, c + 1});
    do_commit();
    wait_to(c + 10);
    wr(5'd2, 8'h41);
    do_commit();
    ef2 = putc(ef, 2, 8'h41);
    exp_q.push_back('{ef2, c + 99});
    wait_to(c + 20);
    do_commit();
    wait_to(c + 50); chk("hold_frame_mid", frame, ef);
    wait_to(c + 98); chk("hold_frame_end", frame, ef);
    wait_to(c + 99); chk("hold_frame_new", frame, ef2);
    wait_to(c + 196); chk("second_busy_hold", busy, 1'b1);
    wait_to(c + 197); chk("second_busy_fall", busy, 1'b0);

    // Clear and commit in the same cycle: 32 CLEAR cycles, then a blank frame.
    wr(5'd5, 8'h51);
    c = cyc;
    exp_q.push_back('{SP, c + 33});
    bus.clr_req = 1'b1;
    bus.commit  = 1'b1;
    step();
    bus.clr_req = 1'b0;
    bus.commit  = 1'b0;
    chk("clear_ready_first", bus.wr_ready, 1'b0);
    chk("clear_busy", busy, 1'b1);
    wait_to(c + 32);
    chk("clear_ready_last", bus.wr_ready, 1'b0);
    chk("clear_no_pulse_yet", lcd_rst_n, 1'b1);
    chk("clear_frame_kept", frame, ef2);
    wait_to(c + 33); chk("clear_frame_blank", frame, SP);
    wait_idle();

    // Write accepted together with commit is published.
    c = cyc;
    exp_q.push_back('{putc(SP, 31, 8'h5A), c + 1});
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd31;
    bus.wr_char  = 8'h5A;
    bus.commit   = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.commit   = 1'b0;
    chk("z_last_slot", frame[7:0], 8'h5A);
    wait_idle();

    // Write colliding with clr_req is overwritten by the clear.
    c = cyc;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd3;
    bus.wr_char  = 8'h57;
    bus.clr_req  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
    wait_to(c + 32); chk("clr_only_busy", busy, 1'b1);
    wait_to(c + 33); chk("clr_only_idle", busy, 1'b0);
    exp_q.push_back('{SP, cyc + 1});
    do_commit();
    wait_idle();

    // Reset mid-HOLD with a commit pending: the pending commit is dropped.
    c = cyc;
    exp_q.push_back('{SP, c + 1});
    do_commit();
    wait_to(c + 20);
    do_commit();
    wait_to(c + 40);
    ASYNC_RST = 1'b0;
    #1;
    chk("mid_rst_lcd_rst_n", lcd_rst_n, 1'b0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_frame", frame, SP);
    repeat (3) step();
    ASYNC_RST = 1'b1;
    repeat (250) step();
    chk("post_rst_idle", busy, 1'b0);
    chk("post_rst_lcd_rst_n", lcd_rst_n, 1'b1);
    chk("pulses_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
